if_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline; directly upstream of the ID-stage controller.

---
 rtl/if_stage.sv | 155 +++++++++++++++
 tb/tb_if_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage and IF/ID pipeline register.
// It owns the PC and issues one fetch at a time to instruction memory over a
// req/ack handshake. It delivers IDIR/IDPC/IDVALID to decode and accepts
// stall, redirect and stale-fetch controls from the ID-stage controller.
// The stage has one architectural branch delay slot.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   wpcir                    stall: hold the PC and the IF/ID register
//   branch, jump, jr         a redirect is requested by the instruction in ID
//   brtgt, jaddr, jraddr     the three redirect target sources
//   smc2                     the word now being fetched is stale and must be refetched
//   im_req, im_addr          fetch request and fetch address (im_addr always equals ifpc)
//   im_ack, im_rdata         fetch completion and returned instruction word
//   ifpc                     PC of the instruction being fetched
//   idir, idpc, idvalid      IF/ID register contents (idvalid low marks a bubble)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wpcir,
  input  logic        branch,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] brtgt,
  input  logic [25:0] jaddr,
  input  logic [31:0] jraddr,
  input  logic        smc2,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        im_req,
  output logic [31:0] im_addr,
  output logic [31:0] ifpc,
  output logic [31:0] idir,
  output logic [31:0] idpc,
  output logic        idvalid
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_ir;
  logic [31:0] skid_pc;
  logic        pend;
  logic [31:0] pend_tgt;

  logic        redirect;
  logic        deliver;
  logic [31:0] deliver_ir;
  logic [31:0] deliver_pc;
  logic [31:0] idpc4;
  logic [31:0] target;
  logic [31:0] next_pc;

  assign im_addr = pc;
  assign ifpc    = pc;

  always_comb begin
    idpc4 = idpc + 32'd4;
    // Only one redirect can be outstanding. While one is pending, the delay
    // slot has not reached ID, so a second BRANCH pulse cannot be genuine.
    redirect = branch & idvalid & ~wpcir & ~pend;
    if (jr)
      target = jraddr & 32'hFFFF_FFFC;
    else if (jump)
      target = (idpc4 & 32'hF000_0000) | {4'b0000, jaddr, 2'b00};
    else
      target = brtgt & 32'hFFFF_FFFC;

    deliver    = 1'b0;
    deliver_ir = im_rdata;
    deliver_pc = pc;
    case (state)
      FETCH:   deliver = im_ack & ~smc2 & ~wpcir;
      HOLD: begin
        deliver    = ~smc2 & ~wpcir;
        deliver_ir = skid_ir;
        deliver_pc = skid_pc;
      end
      default: deliver = 1'b0;
    endcase

    // A redirect accepted in the same cycle as its delay slot is delivered
    // steers the PC directly; no pending entry is needed.
    if (redirect)
      next_pc = target;
    else if (pend)
      next_pc = pend_tgt;
    else
      next_pc = pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      idir     <= NOP_WORD;
      idpc     <= 32'h0000_0000;
      idvalid  <= 1'b0;
      im_req   <= 1'b0;
      skid_ir  <= 32'h0000_0000;
      skid_pc  <= 32'h0000_0000;
      pend     <= 1'b0;
      pend_tgt <= 32'h0000_0000;
    end else begin
      if (deliver) begin
        idir    <= deliver_ir;
        idpc    <= deliver_pc;
        idvalid <= 1'b1;
        pc      <= next_pc;
        pend    <= 1'b0;
      end else if (!wpcir) begin
        // No word is ready and the pipe is not stalled, so decode gets a bubble.
        idir    <= NOP_WORD;
        idvalid <= 1'b0;
      end

      if (redirect && !deliver) begin
        pend     <= 1'b1;
        pend_tgt <= target;
      end

      case (state)
        BOOT: begin
          state  <= FETCH;
          im_req <= 1'b1;
        end
        FETCH: begin
          // The word arrived while decode is stalled. Park it in the skid
          // register so that memory is not asked for it a second time.
          if (im_ack && !smc2 && wpcir) begin
            skid_ir <= im_rdata;
            skid_pc <= pc;
            state   <= HOLD;
            im_req  <= 1'b0;
          end
        end
        HOLD: begin
          if (smc2 || !wpcir) begin
            state  <= FETCH;
            im_req <= 1'b1;
          end
        end
        default: begin
          state  <= BOOT;
          im_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wpcir = 1'b0, branch = 1'b0, jump = 1'b0, jr = 1'b0;
  logic [31:0] brtgt = '0, jraddr = '0, im_rdata = '0;
  logic [25:0] jaddr = '0;
  logic        smc2 = 1'b0, im_ack = 1'b0;
  logic        im_req, idvalid;
  logic [31:0] im_addr, ifpc, idir, idpc;

  int vectors = 0;
  int miscompares = 0;

  if_stage #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .wpcir(wpcir), .branch(branch), .jump(jump), .jr(jr),
    .brtgt(brtgt), .jaddr(jaddr), .jraddr(jraddr), .smc2(smc2),
    .im_ack(im_ack), .im_rdata(im_rdata), .im_req(im_req), .im_addr(im_addr),
    .ifpc(ifpc), .idir(idir), .idpc(idpc), .idvalid(idvalid)
  );

  always #5 clk = ~clk;

  // Reference model of the fetch stage. Its phases are: booting, waiting on
  // memory, and holding a word that arrived during a stall.
  localparam int PH_BOOT = 0, PH_WAIT = 1, PH_PARK = 2;
  int          m_phase;
  logic        m_req, m_v, m_pend;
  logic [31:0] m_pc, m_ir, m_idpc, m_park_ir, m_park_pc, m_tgt;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    m_phase = PH_BOOT; m_req = 0; m_v = 0; m_pend = 0;
    m_pc = RST_PC; m_ir = NOP; m_idpc = 0; m_park_ir = 0; m_park_pc = 0; m_tgt = 0;
  endtask

  task automatic model_step();
    logic        took, got;
    logic [31:0] t, w, wpc, jbase;
    took  = branch && m_v && !wpcir && !m_pend;
    jbase = m_idpc + 32'd4;
    if (jr)        t = {jraddr[31:2], 2'b00};
    else if (jump) t = {jbase[31:28], jaddr, 2'b00};
    else           t = {brtgt[31:2], 2'b00};
    got = 0; w = 0; wpc = 0;
    if (m_phase == PH_BOOT) begin
      m_phase = PH_WAIT;
    end else if (m_phase == PH_WAIT) begin
      if (im_ack && !smc2 && !wpcir) begin
        got = 1; w = im_rdata; wpc = m_pc;
      end else if (im_ack && !smc2) begin
        m_park_ir = im_rdata; m_park_pc = m_pc; m_phase = PH_PARK;
      end
    end else begin
      if (smc2) m_phase = PH_WAIT;
      else if (!wpcir) begin
        got = 1; w = m_park_ir; wpc = m_park_pc; m_phase = PH_WAIT;
      end
    end
    if (got) begin
      m_ir = w; m_idpc = wpc; m_v = 1;
      if (took)        m_pc = t;
      else if (m_pend) begin m_pc = m_tgt; m_pend = 0; end
      else             m_pc = m_pc + 32'd4;
    end else begin
      if (!wpcir) begin m_ir = NOP; m_v = 0; end
      if (took) begin m_pend = 1; m_tgt = t; end
    end
    m_req = (m_phase == PH_WAIT);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("im_req", {31'b0, im_req}, {31'b0, m_req});
    chk("im_addr", im_addr, m_pc);
    chk("ifpc", ifpc, m_pc);
    chk("idir", idir, m_ir);
    chk("idpc", idpc, m_idpc);
    chk("idvalid", {31'b0, idvalid}, {31'b0, m_v});
  endtask

  // One clock: check at the falling edge, drive new inputs, then advance the
  // model on the rising edge. Acks are only offered while a request is up.
  task automatic cycle(input int ack_pct, input int stall_pct, input int br_pct, input int smc_pct);
    @(negedge clk);
    check_all();
    im_ack   = m_req && ($urandom_range(99) < ack_pct);
    im_rdata = im_ack ? memw(m_pc) : $urandom;
    wpcir    = ($urandom_range(99) < stall_pct);
    branch   = ($urandom_range(99) < br_pct);
    jump     = ($urandom_range(3) == 0);
    jr       = ($urandom_range(3) == 0);
    brtgt    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF);
    jaddr    = 26'($urandom);
    jraddr   = $urandom;
    smc2     = ($urandom_range(99) < smc_pct);
    @(posedge clk);
    model_step();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    @(posedge clk);
    model_step();
    repeat (20)  cycle(100, 0, 0, 0);
    repeat (40)  cycle(25, 0, 0, 0);
    repeat (40)  cycle(100, 0, 40, 0);
    repeat (60)  cycle(50, 0, 40, 0);
    repeat (80)  cycle(70, 40, 0, 10);
    repeat (800) cycle(60, 30, 35, 8);

    // Assert reset partway through a cycle with a fetch in flight.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_im_req", {31'b0, im_req}, 32'd0);
    chk("rst_ifpc", ifpc, RST_PC);
    chk("rst_idvalid", {31'b0, idvalid}, 32'd0);
    im_ack = 1'b0;
    @(negedge clk);
    check_all();
    rst = 1'b0;
    @(posedge clk);
    model_step();
    repeat (20)  cycle(100, 0, 0, 0);
    repeat (600) cycle(40, 50, 50, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
